// File: rtl/dmem_block_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_block_reader_if
// Purpose  : Request, data-memory and word-stream signals of the block reader.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_block_reader_if #(
    parameter int DATA_W = 17,
    parameter int ADDR_W = 17
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        word_count;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    // Requester / memory / stream-sink side
    modport master (
        output start, base_addr, word_count, mem_rdata, out_ready,
        input  mem_address, mem_we, out_valid, out_data, out_last,
               busy, done, checksum
    );

    // Block reader side
    modport slave (
        input  start, base_addr, word_count, mem_rdata, out_ready,
        output mem_address, mem_we, out_valid, out_data, out_last,
               busy, done, checksum
    );
endinterface
`default_nettype wire

// File: rtl/dmem_block_reader.sv
`default_nettype none
// ============================================================================
// Module   : dmem_block_reader
// Purpose  : Streams a strided block of data-memory words through a 2-entry
//            FIFO. Optional running checksum: define DMEM_READER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_block_reader #(
    parameter int DATA_W = 17,
    parameter int ADDR_W = 17,
    parameter int STRIDE = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dmem_block_reader_if.slave bus
);
    localparam logic [ADDR_W-1:0] c_addr_mask = ADDR_W'(255);
    localparam logic [ADDR_W-1:0] c_stride    = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_remain;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_last0;
    logic              r_last1;
    logic [1:0]        r_count;
    logic              r_busy;
    logic              r_done;

    logic w_pop;
    logic w_push;
    logic w_push_last;

    // A full FIFO may still accept a word when its head leaves this cycle.
    assign w_pop       = (r_count != 2'd0) && bus.out_ready;
    assign w_push      = (r_state == S_FETCH) && (r_remain != 8'd0) &&
                         ((r_count != 2'd2) || w_pop);
    assign w_push_last = (r_remain == 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_data0  <= '0;
            r_data1  <= '0;
            r_last0  <= 1'b0;
            r_last1  <= 1'b0;
            r_count  <= 2'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // Entry 0 is always the head; entry 1 only holds data when full.
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    if (w_push) begin
                        r_data1 <= bus.mem_rdata;
                        r_last1 <= w_push_last;
                    end else begin
                        r_count <= 2'd1;
                    end
                end else if (w_push) begin
                    r_data0 <= bus.mem_rdata;
                    r_last0 <= w_push_last;
                end else begin
                    r_count <= 2'd0;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_data0 <= bus.mem_rdata;
                    r_last0 <= w_push_last;
                    r_count <= 2'd1;
                end else begin
                    r_data1 <= bus.mem_rdata;
                    r_last1 <= w_push_last;
                    r_count <= 2'd2;
                end
            end

            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr   <= bus.base_addr & c_addr_mask;
                        r_remain <= bus.word_count;
                        r_busy   <= 1'b1;
                        if (bus.word_count != 8'd0) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_push) begin
                        r_addr   <= (r_addr + c_stride) & c_addr_mask;
                        r_remain <= r_remain - 8'd1;
                        if (w_push_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && r_last0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_address = r_addr;
    assign bus.mem_we      = 1'b0;
    assign bus.out_valid   = (r_count != 2'd0);
    assign bus.out_data    = r_data0;
    assign bus.out_last    = r_last0 && (r_count != 2'd0);
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

`ifdef DMEM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Restarts on every accepted start, then holds after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + r_data0;
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = '0;
`endif

endmodule
`default_nettype wire
